int_alu_seq: RTL

Parametrised, multi-cycle successor to the 256-bit integer ALU. It sits on the shared 16-bit memory-mapped bus beside the execution unit, which selects it through address[15:12]. Register layout and opcodes keep the existing map, so current firmware runs unchanged. New features: configurable width, iterative multiply and divide, full-width product and remainder, a busy handshake, and error flags.

---
 rtl/int_alu_pkg.sv | 31 +++
 rtl/int_alu_seq_divider.sv | 63 ++++++
 rtl/int_alu_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/int_alu_pkg.sv
// Shared types and constants for the sequential integer ALU: opcodes,
// register map, STATUS_OUT bit positions and controller states.
package int_alu_pkg;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h10,
    OP_SUB  = 8'h11,
    OP_MULT = 8'h12,
    OP_DIV  = 8'h13
  } opcode_t;

  localparam logic [11:0] REG_SRC1       = 12'd0;
  localparam logic [11:0] REG_SRC2       = 12'd1;
  localparam logic [11:0] REG_RESULT     = 12'd2;
  localparam logic [11:0] REG_STATUS_IN  = 12'd3;
  localparam logic [11:0] REG_STATUS_OUT = 12'd4;
  localparam logic [11:0] REG_RESULT_HI  = 12'd5;

  localparam int STAT_DONE    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_DIV0    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_BAD_OP  = 4;
  localparam int STAT_WR_REJ  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/int_alu_seq_divider.sv
// Restoring divider, one quotient bit per cycle; built only with INT_ALU_DIV_EN.
// done is high during the final step, with quotient/remainder showing that step's result.
`ifdef INT_ALU_DIV_EN
module int_alu_seq_divider #(
  parameter int WIDTH = 256
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_nx, quo_nx;
  logic [WIDTH:0]   shifted, trial;
  logic [CW-1:0]    cnt;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    // A negative trial means the divisor did not fit: restore the shifted value.
    if (trial[WIDTH]) begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign done      = busy && (cnt == '0);
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt   <= CW'(WIDTH - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CW'(1);
    end
  end

endmodule
`endif

// File: rtl/int_alu_seq.sv
// Multi-cycle integer ALU on the 16-bit memory-mapped bus; shift-add multiply inside.
// Define INT_ALU_DIV_EN to build the divider; otherwise opcode 0x13 is treated as illegal.
//
// state | meaning
// IDLE  | waiting for a STATUS_IN write; SRC/STATUS_IN writable
// EXEC  | operation running; writes to indices 0..3 rejected
module int_alu_seq
  import int_alu_pkg::*;
#(
  parameter int         WIDTH   = 256,
  parameter logic [3:0] UNIT_ID = 4'h1
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [15:0]      address,
  input  logic             nWrite,
  input  logic             nRead,
  input  logic [WIDTH-1:0] ExeDataOut,
  output logic [WIDTH-1:0] IntDataOut,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);

  state_t state_q, state_d;

  logic [WIDTH-1:0] src1, src2, result, result_hi;
  logic [WIDTH-1:0] mul_hi, mul_lo, mul_hi_nx, mul_lo_nx;
  logic [WIDTH-1:0] rd_data, status_out;
  logic [WIDTH:0]   add_sum, sub_diff, mul_sum;
  logic [7:0]       opcode;
  logic [CW-1:0]    cnt;
  logic [11:0]      idx;
  logic             done, div0, ovf, bad_op, wr_rej;
  logic             sel, wr, rd;
  logic             start_op, complete, op_done;

  assign sel  = (address[15:12] == UNIT_ID);
  assign wr   = sel && !nWrite;
  assign rd   = sel && !nRead;
  assign idx  = address[11:0];
  assign Busy = (state_q == EXEC);

  assign add_sum  = {1'b0, src1} + {1'b0, src2};
  assign sub_diff = {1'b0, src1} - {1'b0, src2};

  // One shift-add step: conditionally add SRC1 into the high half, then shift right.
  assign mul_sum   = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, src1} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], mul_lo[WIDTH-1:1]};

`ifdef INT_ALU_DIV_EN
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_q, div_r;

  assign div_start = start_op && (ExeDataOut[7:0] == OP_DIV) && (src2 != '0);

  int_alu_seq_divider #(.WIDTH(WIDTH)) u_divider (
    .Clk       (Clk),
    .nReset    (nReset),
    .start     (div_start),
    .dividend  (src1),
    .divisor   (src2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`endif

  always_comb begin
    op_done = 1'b1;
    case (opcode)
      OP_MULT: op_done = (cnt == '0);
`ifdef INT_ALU_DIV_EN
      OP_DIV:  op_done = (src2 == '0) || (div_busy && div_done);
`endif
      default: op_done = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_op = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr && (idx == REG_STATUS_IN)) begin
          start_op = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (op_done) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_out              = '0;
    status_out[STAT_DONE]   = done;
    status_out[STAT_BUSY]   = Busy;
    status_out[STAT_DIV0]   = div0;
    status_out[STAT_OVF]    = ovf;
    status_out[STAT_BAD_OP] = bad_op;
    status_out[STAT_WR_REJ] = wr_rej;
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      REG_SRC1:       rd_data = src1;
      REG_SRC2:       rd_data = src2;
      REG_RESULT:     rd_data = result;
      REG_STATUS_IN:  rd_data[7:0] = opcode;
      REG_STATUS_OUT: rd_data = status_out;
      REG_RESULT_HI:  rd_data = result_hi;
      default:        rd_data = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      IntDataOut <= '0;
      src1       <= '0;
      src2       <= '0;
      result     <= '0;
      result_hi  <= '0;
      opcode     <= '0;
      mul_hi     <= '0;
      mul_lo     <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      div0       <= 1'b0;
      ovf        <= 1'b0;
      bad_op     <= 1'b0;
      wr_rej     <= 1'b0;
    end else begin
      if (rd) IntDataOut <= rd_data;
      if (rd && (idx == REG_STATUS_OUT)) wr_rej <= 1'b0;
      if (wr && Busy && (idx <= REG_STATUS_IN)) wr_rej <= 1'b1;

      if (wr && !Busy) begin
        case (idx)
          REG_SRC1: begin
            src1 <= ExeDataOut;
            done <= 1'b0;
          end
          REG_SRC2: begin
            src2 <= ExeDataOut;
            done <= 1'b0;
          end
          REG_STATUS_IN: opcode <= ExeDataOut[7:0];
          default: ;
        endcase
      end

      if (start_op) begin
        done   <= 1'b0;
        div0   <= 1'b0;
        ovf    <= 1'b0;
        bad_op <= 1'b0;
        mul_hi <= '0;
        mul_lo <= src2;
        cnt    <= CW'(WIDTH - 1);
      end

      if (Busy) begin
        mul_hi <= mul_hi_nx;
        mul_lo <= mul_lo_nx;
        if (cnt != '0) cnt <= cnt - CW'(1);
      end

      if (complete) begin
        done <= 1'b1;
        case (opcode)
          OP_ADD: begin
            result <= add_sum[WIDTH-1:0];
            ovf    <= add_sum[WIDTH];
          end
          OP_SUB: begin
            result <= sub_diff[WIDTH-1:0];
            ovf    <= sub_diff[WIDTH];
          end
          OP_MULT: begin
            result    <= mul_lo_nx;
            result_hi <= mul_hi_nx;
            ovf       <= (mul_hi_nx != '0);
          end
`ifdef INT_ALU_DIV_EN
          OP_DIV: begin
            if (src2 == '0) begin
              result    <= '1;
              result_hi <= src1;
              div0      <= 1'b1;
            end else begin
              result    <= div_q;
              result_hi <= div_r;
            end
          end
`endif
          default: bad_op <= 1'b1;
        endcase
      end
    end
  end

endmodule
